// File: rtl/out_byte_uart_tx.sv
// out_byte_uart_tx
// Takes the PicoRV32 console byte stream (out_byte/out_byte_en), buffers it in
// a small FIFO and sends it as 8N1 UART on tx. The CPU is never stalled: a
// byte that arrives while the FIFO is full is dropped and counted.
//
// Ports:
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   out_byte    console byte, valid while out_byte_en is high
//   out_byte_en one-cycle write strobe
//   tx          UART serial output, idles high, driven from a flop
//   busy        FIFO non-empty or a frame is in flight
//   fifo_full   FIFO holds FIFO_DEPTH entries
//   overflow    one-cycle pulse for each dropped byte
//   drop_count  number of dropped bytes, saturating at 255
module out_byte_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] out_byte,
  input  logic       out_byte_en,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int                 BAUD_W     = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0]  BAUD_LOAD  = BAUD_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  state_t             r_state;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [BAUD_W-1:0]  r_baud;
  logic               r_tx;
  logic               r_overflow;
  logic [7:0]         r_drop_count;

  logic               w_full;
  logic               w_empty;
  logic               w_baud_done;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic [7:0]         w_head;

  // Full is judged from the registered count, so a push into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign w_baud_done = (r_baud == '0);
  assign w_push      = out_byte_en && !w_full;
  assign w_drop      = out_byte_en && w_full;
  assign w_head      = r_mem[r_rd_ptr];

  // The FSM takes a byte when idle, or at the very end of a stop bit so that
  // queued frames follow each other with no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

  assign tx         = r_tx;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign fifo_full  = w_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // Storage array needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= out_byte;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Dropped-byte pulse and saturating counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_overflow <= w_drop;
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // Transmit FSM. Each bit lasts CLK_DIV cycles: the baud counter is loaded
  // with CLK_DIV-1 when a bit starts and the bit ends on the edge where it
  // reads zero. tx is always registered here, one edge after the decision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_baud  <= BAUD_LOAD;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_done) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_baud    <= BAUD_LOAD;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        DATA: begin
          if (w_baud_done) begin
            r_baud <= BAUD_LOAD;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              // Next bit is bit 1 of the current register, before the shift.
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_tx    <= 1'b0;
              r_baud  <= BAUD_LOAD;
              r_state <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
